// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares a single 8-bit UART transmitter among NUM_REQ byte-stream
//   requesters. Round-robin arbitration with packet locking: the owner keeps
//   the transmitter until its last byte has gone out, MAX_BURST bytes have
//   been sent, or it drops req_valid. Exactly one byte is in flight at a time:
//   handshake -> tx_start pulse -> wait for tx_done -> next byte.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   req_valid/req_last    per-requester byte valid / end-of-packet flag
//   req_data              byte of requester i at [8*i+7:8*i]
//   req_ready             per-requester accept (one-hot or zero)
//   grant_valid/grant_id  current owner of the transmitter
//   tx_start/tx_data      one-cycle load pulse and the byte to send
//   tx_busy/tx_done       transmitter status, already in the clk domain
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done
);

  localparam int         ID_W      = $clog2(NUM_REQ);
  localparam int         DATA_W    = 8;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [ID_W-1:0]     rr_ptr;
  logic [7:0]          burst_cnt;
  logic                last_q;

  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     cand;
  logic                handshake;
  logic                do_grant;
  logic                do_release;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[DATA_W*i +: DATA_W];
    end
  end

  // Round-robin search starting just after the previous owner. The candidate
  // index wraps explicitly so NUM_REQ need not be a power of two.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Next-state and combinational outputs. Withdrawal in SEND takes priority
  // over a stalled transmitter so an idle owner never blocks the others.
  always_comb begin
    state_n    = state;
    do_grant   = 1'b0;
    do_release = 1'b0;
    handshake  = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          do_grant = 1'b1;
          state_n  = SEND;
        end
      end
      SEND: begin
        req_ready[grant_id] = !tx_busy;
        if (!req_valid[grant_id]) begin
          do_release = 1'b1;
          state_n    = IDLE;
        end else if (!tx_busy) begin
          handshake = 1'b1;
          state_n   = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (last_q || (burst_cnt == BURST_MAX)) begin
            do_release = 1'b1;
            state_n    = IDLE;
          end else begin
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered state: FSM, grant bookkeeping and the byte handed to the UART.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      grant_valid <= 1'b0;
      grant_id    <= '0;
      burst_cnt   <= 8'd0;
      last_q      <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'd0;
    end else begin
      state    <= state_n;
      tx_start <= handshake;
      if (do_grant) begin
        grant_valid <= 1'b1;
        grant_id    <= pick_id;
        burst_cnt   <= 8'd0;
      end
      if (handshake) begin
        tx_data   <= data_arr[grant_id];
        last_q    <= req_last[grant_id];
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (do_release) begin
        rr_ptr      <= grant_id;
        grant_valid <= 1'b0;
        burst_cnt   <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. Requesters are byte queues that
//   hold req_valid while they have data; a simple transmitter answers each
//   tx_start with tx_done after a programmable delay. A packet-level model
//   predicts the (owner, byte) order of every transmitted byte.
module tb_uart_tx_arbiter;
  localparam int NR   = 4;
  localparam int MAXB = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              grant_valid;
  logic [1:0]        grant_id;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_done;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // requester byte queues: bit 8 = last flag
  logic [8:0] rq [NR][$];
  int         exp_id [$];
  logic [7:0] exp_b [$];
  int         start_log [$];
  int         mptr;
  int         n_starts = 0;
  bit         inflight = 0;
  bit         fly_chk  = 0;
  int         tcnt     = 0;
  logic [7:0] fly_data = 8'h00;
  int         tx_delay = 4;
  bit         force_busy = 0;
  bit         force_done = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packet-level prediction: round robin over requesters with pending bytes,
  // each grant sending until a last byte, MAXB bytes, or the queue runs dry.
  task automatic model_round();
    logic [8:0] q [NR][$];
    logic [8:0] e;
    int pick, n;
    for (int i = 0; i < NR; i++) q[i] = rq[i];
    forever begin
      pick = -1;
      for (int k = 1; k <= NR; k++)
        if (pick < 0 && q[(mptr + k) % NR].size() > 0) pick = (mptr + k) % NR;
      if (pick < 0) break;
      n = 0;
      while (q[pick].size() > 0) begin
        e = q[pick].pop_front();
        n++;
        exp_id.push_back(pick);
        exp_b.push_back(e[7:0]);
        if (e[8] || n == MAXB) break;
      end
      mptr = pick;
    end
  endtask

  function automatic bit pending();
    bit p;
    p = inflight || grant_valid || tx_done || (exp_id.size() > 0);
    for (int i = 0; i < NR; i++) if (rq[i].size() > 0) p = 1;
    return p;
  endfunction

  // One clock: predict the handshake, observe the edge, update the
  // transmitter and requesters, drive new inputs.
  task automatic step();
    bit hs;
    int hid;
    hs = 0;
    hid = 0;
    check_val("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (req_ready != '0) check_val("ready_owner", 32'(req_ready), 32'(4'b0001 << grant_id));
    for (int i = 0; i < NR; i++)
      if (req_ready[i] && req_valid[i]) begin hs = 1; hid = i; end
    if (reset) hs = 0;
    @(posedge clk); #1;
    if (hs) void'(rq[hid].pop_front());
    check_val("start_latency", 32'(tx_start), 32'(hs));
    tx_done = 1'b0;
    if (tx_start) begin
      n_starts++;
      start_log.push_back(int'(grant_id));
      check_val("overlap", 32'(inflight), 32'd0);
      if (exp_id.size() == 0) check_val("extra_start", 32'(tx_start), 32'd0);
      else begin
        check_val("tx_id", 32'(grant_id), 32'(exp_id.pop_front()));
        check_val("tx_data", 32'(tx_data), 32'(exp_b.pop_front()));
      end
    end else if (inflight) begin
      if (fly_chk) check_val("data_stable", 32'(tx_data), 32'(fly_data));
      tcnt--;
      if (tcnt <= 0) begin tx_done = 1'b1; inflight = 0; end
    end
    if (tx_start) begin inflight = 1; tcnt = tx_delay; fly_data = tx_data; fly_chk = 1; end
    if (force_done) begin tx_done = 1'b1; force_done = 0; end
    tx_busy = inflight | force_busy;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i] = rq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_id.delete();
    exp_b.delete();
    mptr = NR - 1;
    fly_chk = 0;
    step();
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_gvalid", 32'(grant_valid), 32'd0);
    check_val("rst_gid", 32'(grant_id), 32'd0);
    check_val("rst_start", 32'(tx_start), 32'd0);
    check_val("rst_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
  endtask

  task automatic run_until_idle(input int limit);
    int g;
    g = 0;
    while (pending() && g < limit) begin step(); g++; end
    check_val("timeout", 32'(g < limit), 32'd1);
    check_val("drained", 32'(exp_id.size()), 32'd0);
  endtask

  initial begin
    int s0, g;
    int ord [5];
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    ord = '{0, 1, 2, 3, 0};

    // 1: two-byte packet from requester 0
    do_reset();
    tx_delay = 20;
    rq[0].push_back(9'h055);
    rq[0].push_back(9'h1AA);
    model_round();
    s0 = n_starts;
    run_until_idle(500);
    check_val("t1_starts", 32'(n_starts - s0), 32'd2);
    check_val("t1_gvalid", 32'(grant_valid), 32'd0);

    // 2: four requesters, one-byte packets
    do_reset();
    tx_delay = 3;
    rq[0].push_back(9'h101); rq[0].push_back(9'h102);
    rq[1].push_back(9'h111);
    rq[2].push_back(9'h122);
    rq[3].push_back(9'h133);
    model_round();
    start_log.delete();
    run_until_idle(500);
    check_val("t2_count", 32'(start_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < start_log.size(); i++)
      check_val("t2_order", 32'(start_log[i]), 32'(ord[i]));

    // 3: burst limit forces rotation
    tx_delay = 2;
    for (int i = 0; i < 40; i++) rq[1].push_back({1'b0, 8'(i + 8'h40)});
    rq[2].push_back(9'h1E1);
    rq[2].push_back(9'h1E2);
    model_round();
    start_log.delete();
    run_until_idle(2000);
    check_val("t3_count", 32'(start_log.size()), 32'd42);
    if (start_log.size() >= 18) begin
      check_val("t3_first", 32'(start_log[15]), 32'd1);
      check_val("t3_rotate", 32'(start_log[16]), 32'd2);
      check_val("t3_regain", 32'(start_log[17]), 32'd1);
    end

    // 4: transmitter busy holds off the handshake
    force_busy = 1;
    rq[0].push_back(9'h181);
    model_round();
    s0 = n_starts;
    repeat (6) begin
      step();
      check_val("t4_ready", 32'(req_ready), 32'd0);
    end
    check_val("t4_gvalid", 32'(grant_valid), 32'd1);
    check_val("t4_nostart", 32'(n_starts - s0), 32'd0);
    force_busy = 0;
    run_until_idle(200);
    check_val("t4_start", 32'(n_starts - s0), 32'd1);

    // 5: owner withdraws without last; spurious tx_done in IDLE
    tx_delay = 5;
    rq[1].push_back(9'h03C);
    model_round();
    g = 0;
    while (!tx_done && g < 200) begin step(); g++; end
    check_val("t5_done_seen", 32'(tx_done), 32'd1);
    step();
    check_val("t5_hold", 32'(grant_valid), 32'd1);
    step();
    check_val("t5_release", 32'(grant_valid), 32'd0);
    run_until_idle(100);
    s0 = n_starts;
    force_done = 1;
    repeat (5) step();
    check_val("t5_spurious", 32'(n_starts - s0), 32'd0);
    check_val("t5_idle", 32'(grant_valid), 32'd0);
    rq[0].push_back(9'h1A0);
    rq[2].push_back(9'h1A2);
    model_round();
    start_log.delete();
    run_until_idle(200);
    if (start_log.size() > 0) check_val("t5_next", 32'(start_log[0]), 32'd2);
    else check_val("t5_next_none", 32'(start_log.size()), 32'd1);

    // 6: reset mid-byte, late tx_done ignored
    tx_delay = 20;
    for (int i = 0; i < 4; i++) rq[2].push_back({1'b0, 8'(8'hC0 + i)});
    model_round();
    s0 = n_starts;
    g = 0;
    while (n_starts == s0 && g < 100) begin step(); g++; end
    check_val("t6_started", 32'(n_starts - s0), 32'd1);
    repeat (3) step();
    do_reset();
    s0 = n_starts;
    g = 0;
    while (inflight && g < 100) begin step(); g++; end
    repeat (3) step();
    check_val("t6_ignored", 32'(n_starts - s0), 32'd0);
    check_val("t6_gvalid", 32'(grant_valid), 32'd0);
    rq[3].push_back(9'h1D3);
    rq[0].push_back(9'h1D0);
    model_round();
    start_log.delete();
    run_until_idle(200);
    if (start_log.size() > 0) check_val("t6_first", 32'(start_log[0]), 32'd0);
    else check_val("t6_first_none", 32'(start_log.size()), 32'd1);

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      tx_delay = $urandom_range(1, 8);
      for (int i = 0; i < NR; i++) begin
        int n;
        n = $urandom_range(0, 25);
        for (int k = 0; k < n; k++)
          rq[i].push_back({1'($urandom_range(0, 3) == 0), 8'($urandom)});
      end
      model_round();
      run_until_idle(8000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
